// File: rtl/if_program_loader.sv
// Receives a program as a byte stream (MSB first, four bytes per word) and writes each
// assembled word into instruction memory, stopping at a zero (HALT) word or when memory is full.
module if_program_loader #(
   parameter int NB_INST = 32,
   parameter int NB_ADDR = 32,
   parameter int NB_DATA = 8,
   parameter int N_WORDS = 64
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   output logic               o_write,
   output logic [NB_ADDR-1:0] o_address,
   output logic [NB_INST-1:0] o_instruction,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error,
   output logic [NB_ADDR-1:0] o_word_count
);

   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);
   localparam logic [NB_ADDR-1:0] ONE       = NB_ADDR'(1);

   state_t             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [NB_INST-1:0] word_q, word_d;
   logic [NB_INST-1:0] instr_q, instr_d;
   logic [NB_ADDR-1:0] addr_q, addr_d;
   logic [NB_ADDR-1:0] waddr_q, waddr_d;
   logic [NB_ADDR-1:0] count_q, count_d;
   logic [NB_INST-1:0] shifted;

   assign shifted = {word_q[NB_INST-NB_DATA-1:0], i_rx_data};

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         instr_q <= '0;
         addr_q  <= '0;
         waddr_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         waddr_q <= waddr_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      waddr_d = waddr_q;
      count_d = count_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (i_start) begin
               state_d = RECV;
               cnt_d   = '0;
               word_d  = '0;
               addr_d  = '0;
               count_d = '0;
            end
         end
         RECV: begin
            if (i_rx_done) begin
               word_d = shifted;
               cnt_d  = cnt_q + 2'd1;
               // Write-port registers are loaded only here so they hold between writes.
               if (cnt_q == 2'd3) begin
                  state_d = WRITE;
                  waddr_d = addr_q;
                  instr_d = shifted;
               end
            end
         end
         WRITE: begin
            count_d = count_q + ONE;
            if (word_q == '0) begin
               state_d = DONE;
            end else if (addr_q == LAST_ADDR) begin
               state_d = ERROR;
            end else begin
               state_d = RECV;
               addr_d  = addr_q + ONE;
               // A byte arriving during the write cycle starts the next word.
               if (i_rx_done) begin
                  word_d = shifted;
                  cnt_d  = 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_write       = (state_q == WRITE);
   assign o_busy        = (state_q == RECV) || (state_q == WRITE);
   assign o_done        = (state_q == DONE);
   assign o_error       = (state_q == ERROR);
   assign o_address     = waddr_q;
   assign o_instruction = instr_q;
   assign o_word_count  = count_q;

endmodule

// File: tb/tb_if_program_loader.sv
// Bench for if_program_loader: directed scenarios with literal expectations, then random
// byte streams checked every cycle against a word-level model of the loader.
module tb_if_program_loader;

   localparam int NW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        rx_done = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        o_write, o_busy, o_done, o_error;
   logic [31:0] o_address, o_instruction, o_word_count;

   int tests = 0;
   int fails = 0;
   logic [31:0] log_addr[$];
   logic [31:0] log_instr[$];

   // model state: word-level view of a load
   bit          m_load, m_wr, m_done, m_err;
   int          m_n;
   logic [31:0] m_acc, m_idx, m_cnt, m_waddr, m_winstr;

   if_program_loader #(.NB_INST(32), .NB_ADDR(32), .NB_DATA(8), .N_WORDS(NW)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
      .o_write(o_write), .o_address(o_address), .o_instruction(o_instruction), .o_busy(o_busy),
      .o_done(o_done), .o_error(o_error), .o_word_count(o_word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // reference model
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_load = 0; m_wr = 0; m_done = 0; m_err = 0; m_n = 0;
            m_acc = 0; m_idx = 0; m_cnt = 0; m_waddr = 0; m_winstr = 0;
         end else if (m_wr) begin
            m_wr = 0;
            m_cnt = m_cnt + 1;
            if (m_winstr == 0) m_done = 1;
            else if (m_idx == NW - 1) m_err = 1;
            else begin
               m_idx = m_idx + 1;
               m_load = 1;
               m_n = 0;
               if (rx_done) begin
                  m_acc = {m_acc[23:0], rx_data};
                  m_n = 1;
               end
            end
         end else if (m_load) begin
            if (rx_done) begin
               m_acc = {m_acc[23:0], rx_data};
               m_n = m_n + 1;
               if (m_n == 4) begin
                  m_n = 0; m_load = 0; m_wr = 1;
                  m_waddr = m_idx; m_winstr = m_acc;
               end
            end
         end else if (start) begin
            m_load = 1; m_n = 0; m_acc = 0; m_idx = 0; m_cnt = 0; m_done = 0; m_err = 0;
         end
      end
   end

   // per-cycle compare and write logger
   initial begin
      forever begin
         @(negedge clk);
         #1;
         chk("write", o_write, m_wr);
         chk("busy", o_busy, m_load | m_wr);
         chk("done", o_done, m_done);
         chk("error", o_error, m_err);
         chk("address", o_address, m_waddr);
         chk("instruction", o_instruction, m_winstr);
         chk("word_count", o_word_count, m_cnt);
         if (o_write) begin
            log_addr.push_back(o_address);
            log_instr.push_back(o_instruction);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
      rx_done = 1'b0;
      repeat (2) @(negedge clk);
      #2;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_instr.delete();
   endtask

   task automatic chk_log(input string nm, input int i, input logic [31:0] a, input logic [31:0] d);
      if (i < log_addr.size()) begin
         chk({nm, "_addr"}, log_addr[i], a);
         chk({nm, "_instr"}, log_instr[i], d);
      end else begin
         chk({nm, "_present"}, 0, 1);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #2;
      chk("reset_busy", o_busy, 0);
      chk("reset_instr", o_instruction, 0);
      chk("reset_count", o_word_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single word, loader returns to receive
      clear_log();
      pulse_start();
      send_word(32'h00223021);
      chk("s1_nwrites", log_addr.size(), 1);
      chk_log("s1_w0", 0, 0, 32'h00223021);
      chk("s1_busy", o_busy, 1);
      chk("s1_count", o_word_count, 1);

      // HALT word ends the load
      send_word(32'h0);
      chk("s2_nwrites", log_addr.size(), 2);
      chk_log("s2_w1", 1, 1, 32'h0);
      chk("s2_done", o_done, 1);
      chk("s2_count", o_word_count, 2);

      // memory fills without HALT
      clear_log();
      pulse_start();
      for (int i = 0; i < NW; i++) send_word(32'h11111111 * (i + 1));
      for (int i = 0; i < NW; i++) chk_log("s3_w", i, i, 32'h11111111 * (i + 1));
      chk("s3_error", o_error, 1);
      chk("s3_count", o_word_count, NW);
      send_word(32'hDEADBEEF);
      chk("s3_nwrites", log_addr.size(), NW);
      chk("s3_count_after", o_word_count, NW);

      // reset in the middle of a word
      clear_log();
      pulse_start();
      send_byte(8'h12);
      send_byte(8'h34);
      rx_done = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("s4_busy_now", o_busy, 0);
      chk("s4_instr_now", o_instruction, 0);
      chk("s4_count_now", o_word_count, 0);
      chk("s4_error_now", o_error, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_word(32'h01020304);
      chk("s4_no_write", log_addr.size(), 0);
      pulse_start();
      send_word(32'hAABBCCDD);
      chk_log("s4_w0", 0, 0, 32'hAABBCCDD);
      send_word(32'h0);

      // byte during the write cycle, start ignored while receiving
      clear_log();
      pulse_start();
      foreach (log_addr[i]) ;
      begin
         logic [63:0] burst;
         burst = 64'h0102030455667788;
         for (int i = 7; i >= 0; i--) send_byte(burst[8*i +: 8]);
      end
      rx_done = 1'b0;
      repeat (2) @(negedge clk);
      chk_log("s5_w0", 0, 0, 32'h01020304);
      chk_log("s5_w1", 1, 1, 32'h55667788);
      pulse_start();
      send_word(32'h0);
      chk_log("s5_w2", 2, 2, 32'h0);
      chk("s5_count", o_word_count, 3);
      chk("s5_done", o_done, 1);

      // random streams
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(0, 599) != 0);
         start   = ($urandom_range(0, 29) == 0);
         rx_done = $urandom_range(0, 1);
         rx_data = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom);
         @(negedge clk);
      end
      rst_n = 1'b1;
      start = 1'b0;
      rx_done = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_program_loader.md
IF_PROGRAM_LOADER -- requirements
Module: if_program_loader

Interface
REQ-001 SHALL have parameter NB_INST, default 32, instruction word width.
REQ-002 SHALL have parameter NB_ADDR, default 32, instruction memory address width.
REQ-003 SHALL have parameter NB_DATA, default 8, received byte width.
REQ-004 SHALL have parameter N_WORDS, default 64, instruction memory depth in words.
REQ-005 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_start  input  1  one-cycle pulse that arms a load from address 0.
REQ-008 SHALL have port i_rx_data  input  NB_DATA  received byte, valid only when i_rx_done=1.
REQ-009 SHALL have port i_rx_done  input  1  one-cycle strobe, byte available.
REQ-010 SHALL have port o_write  output  1  write strobe to instruction memory.
REQ-011 SHALL have port o_address  output  NB_ADDR  word index for the write.
REQ-012 SHALL have port o_instruction  output  NB_INST  assembled instruction for the write.
REQ-013 SHALL have port o_busy  output  1  high in RECV and WRITE.
REQ-014 SHALL have port o_done  output  1  high in DONE.
REQ-015 SHALL have port o_error  output  1  high in ERROR.
REQ-016 SHALL have port o_word_count  output  NB_ADDR  words written in current or last load, HALT included.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE, DONE, ERROR, all registered.
REQ-018 IDLE/DONE/ERROR: i_start=1 -> RECV next cycle; clear byte counter, word register, address, o_word_count; i_rx_done ignored.
REQ-019 RECV: each i_rx_done=1 shifts word <= {word[NB_INST-NB_DATA-1:0], i_rx_data} (first byte = MSB) and increments 2-bit byte counter.
REQ-020 RECV: strobe completing the 4th byte -> WRITE next cycle; byte counter wraps to 0.
REQ-021 WRITE: lasts exactly one cycle with o_write=1, o_address=current index, o_instruction=assembled word; o_write=0 in every other state.
REQ-022 WRITE: o_word_count increments by 1 in the same edge that leaves WRITE.
REQ-023 WRITE, word == 0 (HALT): -> DONE; address unchanged.
REQ-024 WRITE, word != 0, address == N_WORDS-1: -> ERROR (memory full without HALT).
REQ-025 WRITE, otherwise: address += 1, -> RECV.
REQ-026 WRITE with i_rx_done=1 and next state RECV: that byte SHALL be taken as first byte of the next word (counter = 1); when next state is DONE or ERROR it is dropped.
REQ-027 i_start in RECV or WRITE SHALL be ignored; a load cannot be restarted mid-word except by reset.
REQ-028 i_start and i_rx_done together in IDLE/DONE/ERROR: start wins, byte dropped.
REQ-029 o_address/o_instruction SHALL hold their last values outside WRITE; address never exceeds N_WORDS-1.
REQ-030 Write-to-memory latency: 4th byte strobe at edge n -> o_write high during cycle n+1.

Reset
REQ-031 i_reset=0 SHALL immediately, regardless of clock, force IDLE, byte counter 0, word register 0, address 0.
REQ-032 Reset values: o_write=0, o_address=0, o_instruction=0, o_busy=0, o_done=0, o_error=0, o_word_count=0.
REQ-033 Reset asserted mid-load SHALL discard the partial word; no o_write may occur until a new i_start.

Verification
REQ-034 Start, bytes 00 22 30 21 -> one o_write cycle, o_address=0, o_instruction=32'h00223021, back in RECV, o_word_count=1.
REQ-035 Start, word 32'h00223021 then 00 00 00 00 -> writes at addresses 0 and 1, second value 0, o_done=1, o_word_count=2.
REQ-036 N_WORDS=4, four nonzero words -> writes at 0..3, o_error=1 after 4th write, o_word_count=4, further bytes ignored.
REQ-037 Two bytes sent, i_reset=0 mid-cycle -> outputs zero immediately; after release and new start, 4 bytes AA BB CC DD -> o_instruction=32'hAABBCCDD at address 0.
REQ-038 Byte strobe coincident with WRITE of non-HALT word, then 3 more bytes -> second word contains that byte as MSB; i_start during RECV -> no effect on address or count.
